// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sequencer sharing one combinational ALU between two requesters.
//   clk, rst_n              clock, synchronous active-low reset
//   req_valid/req_ready     per-requester request handshake (bit i = requester i)
//   req_op/req_a/req_b      packed per-requester op code and operands
//   rsp_valid/rsp_ready     per-requester response handshake
//   rsp_q/rsp_cmp/rsp_err   shared response bus, qualified by rsp_valid
//   alu_s/alu_a/alu_b       latched op and operands driven to the ALU
//   alu_q/alu_cmp           ALU result and compare flag
module alu_share_ctrl #(
  parameter int DATA_W = 32,
  parameter int OP_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*OP_W-1:0]   req_op,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [DATA_W-1:0]   rsp_q,
  output logic                rsp_cmp,
  output logic                rsp_err,
  output logic [OP_W-1:0]     alu_s,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  input  logic [DATA_W-1:0]   alu_q,
  input  logic                alu_cmp
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic gnt_id, last_grant, win_id, accept, op_ok;
  function automatic logic legal(input logic [OP_W-1:0] op);
    case (op)
      OP_W'(1), OP_W'(33), OP_W'(29), OP_W'(25), OP_W'(17), OP_W'(5), OP_W'(53),
      OP_W'(21), OP_W'(9), OP_W'(13), OP_W'(3), OP_W'(35), OP_W'(7), OP_W'(39),
      OP_W'(19), OP_W'(51), OP_W'(23), OP_W'(55), OP_W'(27), OP_W'(59),
      OP_W'(31), OP_W'(63): legal = 1'b1;
      default: legal = 1'b0;
    endcase
  endfunction
  // On a tie the requester that did not win last time is granted.
  // req_ready is held low during reset so nothing can handshake.
  always_comb begin
    win_id = (&req_valid) ? ~last_grant : req_valid[1];
    accept = rst_n && (state == IDLE) && (|req_valid);
    req_ready = accept ? (win_id ? 2'b10 : 2'b01) : 2'b00;
    rsp_valid = (state == RESP) ? {gnt_id, ~gnt_id} : 2'b00;
    op_ok = legal(alu_s);
    state_nx = (state == IDLE) ? (accept ? EXEC : IDLE) :
               (state == EXEC) ? RESP :
               (rsp_ready[gnt_id] ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_id <= 1'b0;
      last_grant <= 1'b1;
      alu_s <= '0;
      alu_a <= '0;
      alu_b <= '0;
      rsp_q <= '0;
      rsp_cmp <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      if (accept) begin
        gnt_id <= win_id;
        last_grant <= win_id;
        alu_s <= win_id ? req_op[2*OP_W-1:OP_W] : req_op[OP_W-1:0];
        alu_a <= win_id ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
        alu_b <= win_id ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
      end
      // Result capture; an illegal op zeroes the data and raises the error flag.
      if (state == EXEC) begin
        rsp_q <= op_ok ? alu_q : '0;
        rsp_cmp <= op_ok && alu_cmp;
        rsp_err <= ~op_ok;
      end
    end
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed self-checking bench for alu_share_ctrl with a behavioural ALU.
module tb_alu_share_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [11:0] req_op;
  logic [63:0] req_a, req_b;
  logic [31:0] rsp_q, alu_a, alu_b, alu_q;
  logic rsp_cmp, rsp_err, alu_cmp;
  logic [5:0] alu_s;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  alu_share_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_q(rsp_q), .rsp_cmp(rsp_cmp), .rsp_err(rsp_err),
    .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_q(alu_q), .alu_cmp(alu_cmp)
  );
  // Behavioural ALU; unknown ops give nonzero outputs so forcing to zero is observable.
  always_comb begin
    alu_q = 32'd0;
    alu_cmp = 1'b0;
    case (alu_s)
      6'd1: alu_q = alu_a + alu_b;
      6'd33: alu_q = alu_a - alu_b;
      6'd29: alu_q = alu_a & alu_b;
      6'd25: alu_q = alu_a | alu_b;
      6'd17: alu_q = alu_a ^ alu_b;
      6'd5: alu_q = alu_a << alu_b[4:0];
      6'd53: alu_q = alu_a >> alu_b[4:0];
      6'd21: alu_q = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      6'd9: alu_q = ~(alu_a | alu_b);
      6'd13: alu_q = {31'd0, alu_a < alu_b};
      6'd3: alu_cmp = alu_a == alu_b;
      6'd35: alu_cmp = alu_a != alu_b;
      6'd7, 6'd39, 6'd19, 6'd51, 6'd23, 6'd55, 6'd27, 6'd59, 6'd31, 6'd63: alu_cmp = alu_a < alu_b;
      default: begin
        alu_q = alu_a + alu_b;
        alu_cmp = 1'b1;
      end
    endcase
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if (rsp_valid !== 2'b00 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_hs got valid=%b ready=%b exp 00 00", rsp_valid, req_ready);
    end
    checks++;
    if (rsp_q !== 32'd0 || rsp_cmp !== 1'b0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp got q=%h cmp=%b err=%b exp 0 0 0", rsp_q, rsp_cmp, rsp_err);
    end
    checks++;
    if (alu_s !== 6'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      errors++;
      $display("FAIL reset_alu got s=%0d a=%h b=%h exp 0 0 0", alu_s, alu_a, alu_b);
    end
  endtask
  task automatic test_single();
    req_valid = 2'b01;
    req_op[5:0] = 6'd1;
    req_a[31:0] = 32'd5;
    req_b[31:0] = 32'd7;
    rsp_ready = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_ready got %b exp 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    #1;
    checks++;
    if (rsp_valid !== 2'b00 || req_ready !== 2'b00 || alu_s !== 6'd1 || alu_a !== 32'd5 || alu_b !== 32'd7) begin
      errors++;
      $display("FAIL single_exec got valid=%b ready=%b s=%0d a=%0d b=%0d exp 00 00 1 5 7", rsp_valid, req_ready, alu_s, alu_a, alu_b);
    end
    tick();
    checks++;
    if (rsp_valid !== 2'b01 || rsp_q !== 32'd12 || rsp_cmp !== 1'b0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp got valid=%b q=%0d cmp=%b err=%b exp 01 12 0 0", rsp_valid, rsp_q, rsp_cmp, rsp_err);
    end
    tick();
    checks++;
    if (rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL single_done got valid=%b exp 00", rsp_valid);
    end
  endtask
  task automatic test_tie();
    do_reset();
    req_valid = 2'b11;
    req_op = {6'd3, 6'd33};
    req_a = {32'd4, 32'd10};
    req_b = {32'd4, 32'd3};
    rsp_ready = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL tie_first got %b exp 01", req_ready);
    end
    tick();
    tick();
    checks++;
    if (rsp_valid !== 2'b01 || rsp_q !== 32'd7 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL tie_rsp0 got valid=%b q=%0d err=%b exp 01 7 0", rsp_valid, rsp_q, rsp_err);
    end
    tick();
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL tie_second got %b exp 10", req_ready);
    end
    tick();
    tick();
    checks++;
    if (rsp_valid !== 2'b10 || rsp_q !== 32'd0 || rsp_cmp !== 1'b1) begin
      errors++;
      $display("FAIL tie_rsp1 got valid=%b q=%0d cmp=%b exp 10 0 1", rsp_valid, rsp_q, rsp_cmp);
    end
    tick();
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL tie_third got %b exp 01", req_ready);
    end
    tick();
    tick();
    tick();
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL tie_fourth got %b exp 10", req_ready);
    end
    req_valid = 2'b00;
    tick();
    tick();
    tick();
  endtask
  task automatic test_backpressure();
    req_valid = 2'b01;
    req_op[5:0] = 6'd29;
    req_a[31:0] = 32'h0000F0F0;
    req_b[31:0] = 32'h0000FF00;
    rsp_ready = 2'b00;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      rsp_ready = (i > 2) ? 2'b10 : 2'b00;
      #1;
      checks++;
      if (rsp_valid !== 2'b01 || rsp_q !== 32'h0000F000 || req_ready !== 2'b00) begin
        errors++;
        $display("FAIL bp_hold%0d got valid=%b q=%h ready=%b exp 01 0000f000 00", i, rsp_valid, rsp_q, req_ready);
      end
      tick();
    end
    rsp_ready = 2'b01;
    tick();
    checks++;
    if (rsp_valid !== 2'b00 || req_ready !== 2'b01) begin
      errors++;
      $display("FAIL bp_done got valid=%b ready=%b exp 00 01", rsp_valid, req_ready);
    end
    req_valid = 2'b00;
    tick();
  endtask
  task automatic test_illegal();
    req_valid = 2'b01;
    req_op[5:0] = 6'd2;
    req_a[31:0] = 32'd1;
    req_b[31:0] = 32'd1;
    rsp_ready = 2'b01;
    tick();
    req_valid = 2'b00;
    tick();
    checks++;
    if (rsp_valid !== 2'b01 || rsp_q !== 32'd0 || rsp_cmp !== 1'b0 || rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_rsp got valid=%b q=%h cmp=%b err=%b exp 01 0 0 1", rsp_valid, rsp_q, rsp_cmp, rsp_err);
    end
    tick();
    req_valid = 2'b01;
    req_op[5:0] = 6'd17;
    req_a[31:0] = 32'h000000FF;
    req_b[31:0] = 32'h0000000F;
    tick();
    req_valid = 2'b00;
    tick();
    checks++;
    if (rsp_valid !== 2'b01 || rsp_q !== 32'h000000F0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL illegal_next got valid=%b q=%h err=%b exp 01 f0 0", rsp_valid, rsp_q, rsp_err);
    end
    tick();
  endtask
  task automatic test_operand_change();
    req_valid = 2'b01;
    req_op[5:0] = 6'd53;
    req_a[31:0] = 32'h80000000;
    req_b[31:0] = 32'd4;
    rsp_ready = 2'b01;
    tick();
    req_valid = 2'b00;
    req_a[31:0] = 32'd0;
    req_op[5:0] = 6'd2;
    #1;
    checks++;
    if (alu_a !== 32'h80000000 || alu_s !== 6'd53) begin
      errors++;
      $display("FAIL opchg_latch got a=%h s=%0d exp 80000000 53", alu_a, alu_s);
    end
    tick();
    checks++;
    if (rsp_valid !== 2'b01 || rsp_q !== 32'h08000000 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL opchg_rsp got valid=%b q=%h err=%b exp 01 08000000 0", rsp_valid, rsp_q, rsp_err);
    end
    tick();
  endtask
  task automatic test_reset_mid_resp();
    req_valid = 2'b10;
    req_op[11:6] = 6'd1;
    req_a[63:32] = 32'd1;
    req_b[63:32] = 32'd2;
    rsp_ready = 2'b00;
    tick();
    req_valid = 2'b00;
    tick();
    checks++;
    if (rsp_valid !== 2'b10 || rsp_q !== 32'd3) begin
      errors++;
      $display("FAIL rstmid_pre got valid=%b q=%0d exp 10 3", rsp_valid, rsp_q);
    end
    rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_ready got %b exp 00", req_ready);
    end
    tick();
    checks++;
    if (rsp_valid !== 2'b00 || rsp_q !== 32'd0 || alu_a !== 32'd0 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_clear got valid=%b q=%h a=%h ready=%b exp 00 0 0 00", rsp_valid, rsp_q, alu_a, req_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rstmid_tie got %b exp 01", req_ready);
    end
    req_valid = 2'b00;
    tick();
  endtask
  initial begin
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_illegal();
    test_operand_change();
    test_reset_mid_resp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
